// File: rtl/sb_cfg_pkg.sv
// Shared constants and FSM state type for the switch box configuration loader.
// The optional parity check in the loader is enabled by defining SB_CFG_PARITY_EN.
package sb_cfg_pkg;

  localparam int CFG_W_DEF = 6;

  // Bit positions of each switch inside one element's configuration word.
  localparam int SB_NE = 0;
  localparam int SB_ES = 1;
  localparam int SB_SW = 2;
  localparam int SB_WN = 3;
  localparam int SB_NS = 4;
  localparam int SB_EW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    ERR    = 2'd3
  } sb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sb_cfg_bank.sv
// Shadow and active configuration storage: words land in the shadow bank one at a
// time and are copied to the active bank in a single edge on the commit strobe.
module sb_cfg_bank
  import sb_cfg_pkg::*;
#(
  parameter int NUM_ELEM = 16,
  parameter int CFG_W    = CFG_W_DEF,
  parameter int IDX_W    = idx_width(NUM_ELEM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_wr_en,
  input  logic [IDX_W-1:0]          i_wr_idx,
  input  logic [CFG_W-1:0]          i_wr_data,
  input  logic                      i_commit,
  output logic [NUM_ELEM*CFG_W-1:0] o_active
);

  logic [NUM_ELEM*CFG_W-1:0] r_shadow;
  logic [NUM_ELEM*CFG_W-1:0] r_active;

  // NOTE: both banks are small flop arrays, so they take the async reset; a reset
  // active bank guarantees every switch is open, and a reset shadow keeps state defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (i_wr_en) begin
      r_shadow[int'(i_wr_idx)*CFG_W +: CFG_W] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
    end else if (i_commit) begin
      r_active <= r_shadow;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/switch_box_config_loader.sv
// Frame loader for switch box configuration: accepts NUM_ELEM words, then commits them
// atomically to sb_c. Define SB_CFG_PARITY_EN to add the cfg_par input and the ERR path.
module switch_box_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int NUM_ELEM = 16,
  parameter int CFG_W    = CFG_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic                      cfg_valid,
  input  logic [CFG_W-1:0]          cfg_data,
`ifdef SB_CFG_PARITY_EN
  input  logic                      cfg_par,
`endif
  output logic                      cfg_ready,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic [NUM_ELEM*CFG_W-1:0] sb_c
);

  localparam int              IDX_W    = idx_width(NUM_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  sb_state_e        r_state;
  sb_state_e        w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;
  logic             w_accept;
  logic             w_restart;
  logic             w_commit;
  logic             w_last;
  logic             w_par_bad;

`ifdef SB_CFG_PARITY_EN
  assign w_par_bad = cfg_par ^ (^cfg_data);
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_last = (r_idx == LAST_IDX);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_restart   = 1'b0;
    w_commit    = 1'b0;
    cfg_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          w_restart   = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        // A restart wins over a word offered in the same cycle.
        if (cfg_start) begin
          w_restart = 1'b1;
        end else if (cfg_valid) begin
          if (w_par_bad) begin
            w_state_nxt = ERR;
          end else begin
            w_accept = 1'b1;
            if (w_last) w_state_nxt = COMMIT;
          end
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      ERR: begin
        if (cfg_start) begin
          w_restart   = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_commit;
      if (w_restart) begin
        r_idx <= '0;
      end else if (w_accept && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

`ifdef SB_CFG_PARITY_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_restart) begin
      r_err <= 1'b0;
    end else if (r_state == LOAD && cfg_valid && w_par_bad) begin
      r_err <= 1'b1;
    end
  end

  assign cfg_err = r_err;
`else
  assign cfg_err = 1'b0;
`endif

  assign cfg_busy = (r_state == LOAD) || (r_state == COMMIT);
  assign cfg_done = r_done;

  sb_cfg_bank #(
    .NUM_ELEM (NUM_ELEM),
    .CFG_W    (CFG_W),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_idx  (r_idx),
    .i_wr_data (cfg_data),
    .i_commit  (w_commit),
    .o_active  (sb_c)
  );

endmodule

// File: doc/switch_box_config_loader.md
SWITCH_BOX_CONFIG_LOADER -- requirements
Module: switch_box_config_loader

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 16, meaning the number of switch box elements configured (range 1..256).
REQ-002 SHALL have parameter CFG_W, default 6, meaning the configuration bits per element (c[0] N-E, c[1] E-S, c[2] S-W, c[3] W-N, c[4] N-S, c[5] E-W).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_start, input, 1, single-cycle request to begin a load frame.
REQ-006 SHALL have port cfg_valid, input, 1, cfg_data holds a valid element word.
REQ-007 SHALL have port cfg_data, input, CFG_W, configuration word for the element at the current index.
REQ-008 SHALL have port cfg_ready, output, 1, loader accepts a word this cycle.
REQ-009 SHALL have port cfg_busy, output, 1, a frame is in progress (LOAD or COMMIT).
REQ-010 SHALL have port cfg_done, output, 1, one-cycle pulse after a successful commit.
REQ-011 SHALL have port cfg_err, output, 1, sticky error flag for the last frame.
REQ-012 SHALL have port sb_c, output, NUM_ELEM*CFG_W, active configuration; element k occupies bits [k*CFG_W +: CFG_W].

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, COMMIT and ERR.
REQ-014 In IDLE, cfg_start SHALL clear the word index and cfg_err and move to LOAD on the next edge.
REQ-015 In LOAD, cfg_ready SHALL be 1; a word is accepted on cycles where cfg_valid && cfg_ready.
REQ-016 An accepted word SHALL be written to shadow[index], and index SHALL increment by 1.
REQ-017 Acceptance of word NUM_ELEM-1 SHALL move the FSM to COMMIT; index does not wrap past NUM_ELEM-1.
REQ-018 COMMIT SHALL last exactly one cycle and copy all shadow entries to sb_c simultaneously (no partial update visible).
REQ-019 cfg_done SHALL be asserted in the cycle after COMMIT, with the FSM back in IDLE.
REQ-020 Latency from the accepting edge of the last word to the sb_c update SHALL be 2 edges.
REQ-021 cfg_ready SHALL be 0 in IDLE, COMMIT and ERR; cfg_valid SHALL be ignored in those states.
REQ-022 cfg_start asserted in LOAD SHALL restart the frame: index set to 0, shadow contents retained but overwritten by subsequent words, sb_c unchanged.
REQ-023 cfg_start and cfg_valid in the same LOAD cycle SHALL give priority to restart; the word is not accepted.
REQ-024 cfg_start in COMMIT SHALL be ignored.
REQ-025 sb_c SHALL change only in COMMIT.
REQ-026 cfg_busy SHALL equal (state==LOAD || state==COMMIT).

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, index 0, shadow all 0, sb_c all 0 (all switches open), cfg_ready 0, cfg_busy 0, cfg_done 0 and cfg_err 0.
REQ-028 Reset asserted mid-LOAD SHALL discard the frame; after release the loader SHALL require a new cfg_start.

Configuration
REQ-029 SHALL recognise macro SB_CFG_PARITY_EN.
REQ-030 With SB_CFG_PARITY_EN defined, the block SHALL add input cfg_par (1 bit, even parity over cfg_data).
REQ-031 With SB_CFG_PARITY_EN defined, an accepted word with a mismatch SHALL move the FSM to ERR and set cfg_err, without COMMIT (sb_c unchanged).
REQ-032 With SB_CFG_PARITY_EN defined, ERR SHALL hold until cfg_start, which SHALL behave as from IDLE.
REQ-033 Without SB_CFG_PARITY_EN, the cfg_par port SHALL be absent, ERR SHALL be unreachable, and cfg_err SHALL be tied to 0.

Structure
REQ-034 Package sb_cfg_pkg SHALL hold the CFG_W default, the switch-bit index constants (SB_NE..SB_EW) and the FSM state typedef.
REQ-035 Shadow and active storage SHALL be a sub-module sb_cfg_bank (write port for shadow, commit strobe for the copy, active output).

Verification
REQ-036 Reset, then cfg_start and 16 words 0x01..0x10 back-to-back -> sb_c element k == k+1, cfg_done pulses once, 2 edges after the last accept.
REQ-037 Gapped cfg_valid (1 in 3 cycles) -> same final sb_c; sb_c stays 0 until COMMIT.
REQ-038 cfg_start after 5 words, then 16 words of 0x3F -> all elements 0x3F; no intermediate sb_c change.
REQ-039 rst_n pulsed low after 8 words -> sb_c == 0, state IDLE, cfg_valid ignored until cfg_start.
REQ-040 With SB_CFG_PARITY_EN defined, a bad parity on word 3 -> cfg_err == 1, cfg_ready == 0, sb_c keeps the prior frame; a following good frame clears cfg_err and commits.
REQ-041 NUM_ELEM=1, word 0x21 -> sb_c == 0x21 (N-E and E-W closed), cfg_done is pulsed.
